// File: rtl/mcpu_core_dtlb.sv
`default_nettype none
// ============================================================================
// Module   : mcpu_core_dtlb
// Brief    : Data-TLB responder. Fully associative virtual-to-physical page
//            cache with a two-level page-table walker behind it. Hits answer
//            one cycle after the request. Misses walk the page tables over a
//            32-bit read port, fill a round-robin slot, and then respond.
// Revision : 1.0 - initial release
// ============================================================================
module mcpu_core_dtlb #(
    parameter int ENTRIES = 8,
    parameter int IDX_W   = 3
) (
    input  logic        clkrst_core_clk,
    input  logic        clkrst_core_rst,
    input  logic [19:0] dtlb_addr,
    input  logic        dtlb_re,
    output logic [3:0]  dtlb_flags,
    output logic [19:0] dtlb_phys_addr,
    output logic        dtlb_ready,
    input  logic        paging_en,
    input  logic [19:0] ptbr,
    input  logic        flush,
    output logic [31:0] walk_addr,
    output logic        walk_re,
    input  logic [31:0] walk_rdata,
    input  logic        walk_valid
);

    localparam logic [2:0] c_IDLE       = 3'd0;
    localparam logic [2:0] c_PDE_REQ    = 3'd1;
    localparam logic [2:0] c_PDE_WAIT   = 3'd2;
    localparam logic [2:0] c_PTE_REQ    = 3'd3;
    localparam logic [2:0] c_PTE_WAIT   = 3'd4;
    localparam logic [2:0] c_RESP_FAULT = 3'd5;

    localparam logic [IDX_W-1:0] c_PTR_ONE = IDX_W'(1);

    // Translation storage
    logic [ENTRIES-1:0] r_valid;
    logic [19:0]        r_vpn   [ENTRIES];
    logic [19:0]        r_ppn   [ENTRIES];
    logic [3:0]         r_flags [ENTRIES];
    logic [IDX_W-1:0]   r_ptr;

    // Walker / response state
    logic [2:0]  r_state;
    logic [19:0] r_req_vpn;
    logic        r_fill_kill;
    logic        r_ready;
    logic [3:0]  r_out_flags;
    logic [19:0] r_out_ppn;
    logic        r_walk_re;
    logic [31:0] r_walk_addr;

    logic [ENTRIES-1:0] w_match;
    logic               w_hit;
    logic [19:0]        w_hit_ppn;
    logic [3:0]         w_hit_flags;
    logic               w_fill;

    // Per-entry tag compare against the incoming virtual page number
    generate
        for (genvar g = 0; g < ENTRIES; g++) begin : g_match
            assign w_match[g] = r_valid[g] && (r_vpn[g] == dtlb_addr);
        end
    endgenerate

    assign w_hit = |w_match;

    // Select the matching entry; at most one entry matches, so OR-ing is a mux
    always_comb begin
        w_hit_ppn   = '0;
        w_hit_flags = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (w_match[i]) begin
                w_hit_ppn   = w_hit_ppn | r_ppn[i];
                w_hit_flags = w_hit_flags | r_flags[i];
            end
        end
    end

    // A completed walk writes an entry unless a flush arrived during the walk
    // or coincides with the completing read
    assign w_fill = (r_state == c_PTE_WAIT) && walk_valid && walk_rdata[0]
                    && !r_fill_kill && !flush;

    // Entry payload write on fill; contents are qualified by r_valid
    always_ff @(posedge clkrst_core_clk) begin
        if (w_fill) begin
            r_vpn[r_ptr]   <= r_req_vpn;
            r_ppn[r_ptr]   <= walk_rdata[31:12];
            r_flags[r_ptr] <= walk_rdata[3:0];
        end
    end

    // Valid bits and round-robin replacement pointer
    always_ff @(posedge clkrst_core_clk) begin
        if (clkrst_core_rst) begin
            r_valid <= '0;
            r_ptr   <= '0;
        end else if (flush) begin
            r_valid <= '0;
            r_ptr   <= '0;
        end else if (w_fill) begin
            r_valid[r_ptr] <= 1'b1;
            r_ptr          <= r_ptr + c_PTR_ONE;
        end
    end

    // Lookup / page-walk state machine with registered outputs
    always_ff @(posedge clkrst_core_clk) begin
        if (clkrst_core_rst) begin
            r_state     <= c_IDLE;
            r_req_vpn   <= '0;
            r_fill_kill <= 1'b0;
            r_ready     <= 1'b1;
            r_out_flags <= '0;
            r_out_ppn   <= '0;
            r_walk_re   <= 1'b0;
            r_walk_addr <= '0;
        end else begin
            r_walk_re <= 1'b0;
            if (flush && (r_state != c_IDLE)) begin
                r_fill_kill <= 1'b1;
            end
            case (r_state)
                c_IDLE: begin
                    if (dtlb_re) begin
                        r_req_vpn   <= dtlb_addr;
                        r_fill_kill <= 1'b0;
                        if (!paging_en) begin
                            r_ready     <= 1'b1;
                            r_out_ppn   <= dtlb_addr;
                            r_out_flags <= 4'hF;
                        end else if (w_hit) begin
                            r_ready     <= 1'b1;
                            r_out_ppn   <= w_hit_ppn;
                            r_out_flags <= w_hit_flags;
                        end else begin
                            r_ready     <= 1'b0;
                            r_state     <= c_PDE_REQ;
                            r_walk_re   <= 1'b1;
                            r_walk_addr <= {ptbr, dtlb_addr[19:10], 2'b00};
                        end
                    end
                end
                c_PDE_REQ: begin
                    r_state <= c_PDE_WAIT;
                end
                c_PDE_WAIT: begin
                    if (walk_valid) begin
                        if (walk_rdata[0]) begin
                            r_state     <= c_PTE_REQ;
                            r_walk_re   <= 1'b1;
                            r_walk_addr <= {walk_rdata[31:12], r_req_vpn[9:0], 2'b00};
                        end else begin
                            r_state <= c_RESP_FAULT;
                        end
                    end
                end
                c_PTE_REQ: begin
                    r_state <= c_PTE_WAIT;
                end
                c_PTE_WAIT: begin
                    if (walk_valid) begin
                        if (walk_rdata[0]) begin
                            r_state     <= c_IDLE;
                            r_ready     <= 1'b1;
                            r_out_ppn   <= walk_rdata[31:12];
                            r_out_flags <= walk_rdata[3:0];
                        end else begin
                            r_state <= c_RESP_FAULT;
                        end
                    end
                end
                c_RESP_FAULT: begin
                    r_state     <= c_IDLE;
                    r_ready     <= 1'b1;
                    r_out_ppn   <= '0;
                    r_out_flags <= '0;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign dtlb_ready     = r_ready;
    assign dtlb_flags     = r_out_flags;
    assign dtlb_phys_addr = r_out_ppn;
    assign walk_re        = r_walk_re;
    assign walk_addr      = r_walk_addr;

endmodule
`default_nettype wire
